// File: rtl/obi_tracker_pkg.sv
// Shared constants and types for the OBI protocol tracker.
package obi_tracker_pkg;

    // Violation vector layout
    localparam int NumViol        = 6;
    localparam int V_GNT_NO_REQ   = 0;
    localparam int V_RVALID_EMPTY = 1;
    localparam int V_OVERFLOW     = 2;
    localparam int V_REQ_DROP     = 3;
    localparam int V_ATTR_CHANGE  = 4;
    localparam int V_LATENCY      = 5;

    // Default-width view of one recorded request (32-bit address/data bus)
    localparam int PkgAddrWidth = 32;
    localparam int PkgBeWidth   = 4;

    typedef struct packed {
        logic [PkgAddrWidth-1:0] addr;
        logic                    we;
        logic [PkgBeWidth-1:0]   be;
    } obi_req_attr_t;

endpackage

// File: rtl/obi_tracker_fifo.sv
// In-order record of accepted requests; non-power-of-2 depths wrap explicitly.
module obi_tracker_fifo #(
    parameter int Depth = 2,
    parameter int Width = 8,
    localparam int CntW = $clog2(Depth + 1),
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] head,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Next-state: write at tail, advance head on pop; push+pop when full reuses the freed slot
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

endmodule

// File: rtl/obi_protocol_tracker.sv
// Observes one OBI channel: tracks outstanding requests in order and flags protocol violations.
module obi_protocol_tracker
    import obi_tracker_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxLatency     = 0,
    parameter bit CheckWdata     = 1'b1,
    localparam int BeWidth = DataWidth / 8,
    localparam int CntW    = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_i,
    input  logic                 gnt_i,
    input  logic                 rvalid_i,
    input  logic                 we_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic [CntW-1:0]      outstanding_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [AddrWidth-1:0] rsp_addr_o,
    output logic                 rsp_we_o,
    output logic [BeWidth-1:0]   rsp_be_o,
    output logic [NumViol-1:0]   viol_o,
    output logic [NumViol-1:0]   viol_sticky_o
);

    localparam int AttrW = AddrWidth + 1 + BeWidth;
    localparam int LatW  = (MaxLatency > 0) ? $clog2(MaxLatency + 1) : 1;

    logic             acc, push, pop;
    logic [AttrW-1:0] head;

    logic                 stall_vld_q, stall_vld_d;
    logic [AddrWidth-1:0] stall_addr_q, stall_addr_d;
    logic                 stall_we_q, stall_we_d;
    logic [BeWidth-1:0]   stall_be_q, stall_be_d;
    logic [DataWidth-1:0] stall_wdata_q, stall_wdata_d;
    logic [LatW-1:0]      lat_q, lat_d;
    logic [NumViol-1:0]   sticky_q, sticky_d;
    logic [CntW-1:0]      count_next;

    // A response never answers a same-cycle grant; a pop frees the slot for a same-cycle push
    assign acc  = req_i & gnt_i;
    assign pop  = rvalid_i & ~empty_o;
    assign push = acc & (~full_o | pop);
    assign count_next = outstanding_o + CntW'(push) - CntW'(pop);

    obi_tracker_fifo #(
        .Depth (MaxOutstanding),
        .Width (AttrW)
    ) u_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({addr_i, we_i, be_i}),
        .head  (head),
        .count (outstanding_o),
        .full  (full_o),
        .empty (empty_o)
    );

    // Head is only meaningful while something is outstanding
    always_comb begin
        {rsp_addr_o, rsp_we_o, rsp_be_o} = empty_o ? '0 : head;
    end

    // Stall capture, head latency and sticky accumulation
    always_comb begin
        stall_vld_d   = req_i & ~gnt_i;
        stall_addr_d  = stall_addr_q;
        stall_we_d    = stall_we_q;
        stall_be_d    = stall_be_q;
        stall_wdata_d = stall_wdata_q;
        if (req_i & ~gnt_i) begin
            stall_addr_d  = addr_i;
            stall_we_d    = we_i;
            stall_be_d    = be_i;
            stall_wdata_d = wdata_i;
        end
        // Restart for each new head; saturate so the latency flag holds until rvalid
        lat_d = lat_q;
        if (pop || count_next == '0)    lat_d = '0;
        else if (lat_q != LatW'(MaxLatency)) lat_d = lat_q + LatW'(1);
        sticky_d = sticky_q | viol_o;
        if (reset) begin
            stall_vld_d   = 1'b0;
            stall_addr_d  = '0;
            stall_we_d    = 1'b0;
            stall_be_d    = '0;
            stall_wdata_d = '0;
            lat_d         = '0;
            sticky_d      = '0;
        end
    end

    // Per-cycle violation checks, silenced during reset
    always_comb begin
        viol_o = '0;
        if (!reset) begin
            viol_o[V_GNT_NO_REQ]   = gnt_i & ~req_i;
            viol_o[V_RVALID_EMPTY] = rvalid_i & empty_o;
            viol_o[V_OVERFLOW]     = acc & full_o & ~rvalid_i;
            viol_o[V_REQ_DROP]     = stall_vld_q & ~req_i;
            viol_o[V_ATTR_CHANGE]  = stall_vld_q & req_i &
                ((addr_i != stall_addr_q) || (we_i != stall_we_q) || (be_i != stall_be_q) ||
                 (CheckWdata && stall_we_q && (wdata_i != stall_wdata_q)));
            viol_o[V_LATENCY]      = (MaxLatency != 0) & ~empty_o &
                                     (lat_q == LatW'(MaxLatency)) & ~rvalid_i;
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        stall_vld_q   <= stall_vld_d;
        stall_addr_q  <= stall_addr_d;
        stall_we_q    <= stall_we_d;
        stall_be_q    <= stall_be_d;
        stall_wdata_q <= stall_wdata_d;
        lat_q         <= lat_d;
        sticky_q      <= sticky_d;
    end

    assign viol_sticky_o = sticky_q;

endmodule

// File: tb/tb_obi_protocol_tracker.sv
// Directed checks of the OBI tracker with MaxOutstanding=2, MaxLatency=3.
module tb_obi_protocol_tracker;

    localparam int GNR = 0, RVE = 1, OVF = 2, DRP = 3, ATC = 4, LAT = 5;

    logic        clock = 1'b0;
    logic        reset, req, gnt, rvalid, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic [1:0]  outstanding;
    logic        full, empty, rsp_we;
    logic [31:0] rsp_addr;
    logic [3:0]  rsp_be;
    logic [5:0]  viol, sticky;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    obi_protocol_tracker #(
        .MaxOutstanding (2),
        .AddrWidth      (32),
        .DataWidth      (32),
        .MaxLatency     (3),
        .CheckWdata     (1'b1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_i         (req),
        .gnt_i         (gnt),
        .rvalid_i      (rvalid),
        .we_i          (we),
        .be_i          (be),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .outstanding_o (outstanding),
        .full_o        (full),
        .empty_o       (empty),
        .rsp_addr_o    (rsp_addr),
        .rsp_we_o      (rsp_we),
        .rsp_be_o      (rsp_be),
        .viol_o        (viol),
        .viol_sticky_o (sticky)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs just after a posedge; settle before sampling
    task automatic drv(input logic r, input logic g, input logic v, input logic [31:0] a,
                       input logic w = 1'b0, input logic [31:0] d = 32'h0);
        req = r; gnt = g; rvalid = v; addr = a; we = w; be = 4'hf; wdata = d;
        #3;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv(0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 1, 0, 0);
        chk("viol_in_reset", 64'(viol), 0);
        tick(); tick();
        reset = 1'b0;
        drv(0, 0, 0, 0);
        chk("rst_cnt", 64'(outstanding), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_full", 64'(full), 0);
        chk("rst_viol", 64'(viol), 0);
        chk("rst_sticky", 64'(sticky), 0);
        chk("rst_rsp", 64'({rsp_addr, rsp_we, rsp_be}), 0);

        // Single transaction
        drv(1, 1, 0, 32'h100);
        chk("t1_viol_a", 64'(viol), 0);
        tick();
        drv(0, 0, 1, 0);
        chk("t1_cnt1", 64'(outstanding), 1);
        chk("t1_rsp", 64'(rsp_addr), 32'h100);
        chk("t1_viol_b", 64'(viol), 0);
        tick();
        drv(0, 0, 0, 0);
        chk("t1_cnt0", 64'(outstanding), 0);
        chk("t1_sticky", 64'(sticky), 0);

        // Fill, overflow, simultaneous push/pop when full, in-order drain
        drv(1, 1, 0, 32'h10); tick();
        drv(1, 1, 0, 32'h20); tick();
        drv(1, 1, 0, 32'h30);
        chk("t2_full", 64'(full), 1);
        chk("t2_cnt", 64'(outstanding), 2);
        chk("t2_ovf", 64'(viol), 64'(1 << OVF));
        tick();
        drv(1, 1, 1, 32'h40);
        chk("t2_cnt_after_ovf", 64'(outstanding), 2);
        chk("t3_viol", 64'(viol), 0);
        chk("t3_rsp", 64'(rsp_addr), 32'h10);
        tick();
        drv(0, 0, 1, 0);
        chk("t3_cnt", 64'(outstanding), 2);
        chk("t3_rsp2", 64'(rsp_addr), 32'h20);
        tick();
        drv(0, 0, 1, 0);
        chk("t3_rsp3", 64'(rsp_addr), 32'h40);
        tick();
        drv(0, 0, 0, 0);
        chk("t3_empty", 64'(empty), 1);
        chk("t2_sticky", 64'(sticky), 64'(1 << OVF));
        do_reset();
        drv(0, 0, 0, 0);
        chk("sticky_cleared", 64'(sticky), 0);

        // Stall attribute change, then request drop
        drv(1, 0, 0, 32'h80);
        chk("t4_stall_ok", 64'(viol), 0);
        tick();
        drv(1, 0, 0, 32'h84);
        chk("t4_attr", 64'(viol), 64'(1 << ATC));
        tick();
        drv(1, 1, 0, 32'h84);
        chk("t4_stable", 64'(viol), 0);
        tick();
        drv(0, 0, 1, 0); tick();
        drv(1, 0, 0, 32'h90); tick();
        drv(0, 0, 0, 0);
        chk("t4_drop", 64'(viol), 64'(1 << DRP));
        tick(); tick();
        chk("t4_sticky", 64'(sticky), 64'((1 << ATC) | (1 << DRP)));
        do_reset();

        // Write data must also hold during a stalled write
        drv(1, 0, 0, 32'hA0, 1'b1, 32'h1111); tick();
        drv(1, 0, 0, 32'hA0, 1'b1, 32'h2222);
        chk("t4_wdata", 64'(viol), 64'(1 << ATC));
        tick();
        do_reset();

        // Grant without request, rvalid when empty (with and without same-cycle grant)
        drv(0, 1, 0, 0);
        chk("t5_gnr", 64'(viol), 64'(1 << GNR));
        tick();
        drv(0, 0, 1, 0);
        chk("t5_rve", 64'(viol), 64'(1 << RVE));
        tick();
        drv(1, 1, 1, 32'h200);
        chk("t5_rve_gnt", 64'(viol), 64'(1 << RVE));
        chk("t5_cnt0", 64'(outstanding), 0);
        tick();
        drv(0, 0, 0, 0);
        chk("t5_cnt1", 64'(outstanding), 1);
        chk("t5_head", 64'(rsp_addr), 32'h200);
        // Reset mid-transaction discards tracking
        do_reset();
        drv(0, 0, 1, 0);
        chk("t5_post_rst_rve", 64'(viol), 64'(1 << RVE));
        tick();
        do_reset();

        // Latency bound: grant at cycle 0, flag on cycles 3 and 4, rvalid at 5
        drv(1, 1, 0, 32'h300);
        chk("t6_c0", 64'(viol), 0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drv(0, 0, 0, 0);
            chk($sformatf("t6_c%0d", c), 64'(viol), (c >= 3) ? 64'(1 << LAT) : 64'h0);
            tick();
        end
        drv(0, 0, 1, 0);
        chk("t6_c5", 64'(viol), 0);
        tick();
        drv(0, 0, 0, 0);
        chk("t6_empty", 64'(empty), 1);
        chk("t6_idle", 64'(viol), 0);
        chk("t6_sticky", 64'(sticky), 64'(1 << LAT));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
